// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH / DECODE / EXEC control with a small return-address stack.
// Every output except ir_load is a register loaded from the next-state decode.
module pc_sequencer #(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic              imem_req,
   input  logic              imem_ack,
   output logic              ir_load,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] target,
   input  logic              zero_flag,
   input  logic [ADDR_W-1:0] pc_value,
   output logic              pc_inc,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_load_addr,
   output logic              exec_en,
   output logic              halted,
   output logic              stack_err
);

   localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_BRZ  = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALTED
   } state_t;

   state_t            state;
   state_t            state_d;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] pc_q;
   logic [PTR_W-1:0]  count;
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   logic              stack_full;
   logic              stack_empty;
   logic [ADDR_W-1:0] stack_top;
   logic              pc_inc_d;
   logic              pc_load_d;
   logic [ADDR_W-1:0] load_addr_d;
   logic              do_push;
   logic              do_pop;
   logic              err_set;

   assign stack_full  = (count == PTR_W'(STACK_DEPTH));
   assign stack_empty = (count == '0);
   assign stack_top   = stack_mem[IDX_W'(count - PTR_W'(1))];

   // Instruction-register strobe follows the memory ack while fetching.
   assign ir_load = (state == S_FETCH) && imem_ack;

   // Next state, plus the PC command that EXEC will present (resolved while in DECODE).
   always_comb begin
      state_d     = state;
      pc_inc_d    = 1'b0;
      pc_load_d   = 1'b0;
      load_addr_d = '0;
      do_push     = 1'b0;
      do_pop      = 1'b0;
      err_set     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_EXEC;
            case (op)
               OP_JMP: begin
                  pc_load_d   = 1'b1;
                  load_addr_d = target;
               end
               OP_BRZ: begin
                  if (zero_flag) begin
                     pc_load_d   = 1'b1;
                     load_addr_d = target;
                  end else begin
                     pc_inc_d = 1'b1;
                  end
               end
               OP_CALL: begin
                  if (!stack_full) begin
                     pc_load_d   = 1'b1;
                     load_addr_d = target;
                  end
               end
               OP_RET: begin
                  if (!stack_empty) begin
                     pc_load_d   = 1'b1;
                     load_addr_d = stack_top;
                  end
               end
               OP_HALT: begin
               end
               default: pc_inc_d = 1'b1;
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (op_q)
               OP_CALL: begin
                  if (stack_full) begin
                     err_set = 1'b1;
                     state_d = S_HALTED;
                  end else begin
                     do_push = 1'b1;
                  end
               end
               OP_RET: begin
                  if (stack_empty) begin
                     err_set = 1'b1;
                     state_d = S_HALTED;
                  end else begin
                     do_pop = 1'b1;
                  end
               end
               OP_HALT: state_d = S_HALTED;
               default: begin
               end
            endcase
         end
         S_HALTED: begin
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_d;
   end

   // Registered outputs and decode/stack bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_req     <= 1'b0;
         exec_en      <= 1'b0;
         halted       <= 1'b0;
         pc_inc       <= 1'b0;
         pc_load      <= 1'b0;
         pc_load_addr <= '0;
         stack_err    <= 1'b0;
         op_q         <= '0;
         pc_q         <= '0;
         count        <= '0;
      end else begin
         imem_req     <= (state_d == S_FETCH);
         exec_en      <= (state_d == S_EXEC);
         halted       <= (state_d == S_HALTED);
         pc_inc       <= pc_inc_d;
         pc_load      <= pc_load_d;
         pc_load_addr <= load_addr_d;
         if (err_set) stack_err <= 1'b1;
         if (state == S_DECODE) begin
            op_q <= op;
            pc_q <= pc_value;
         end
         if (do_push)     count <= count + PTR_W'(1);
         else if (do_pop) count <= count - PTR_W'(1);
      end
   end

   // Return addresses wrap modulo 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (do_push) stack_mem[count[IDX_W-1:0]] <= pc_q + ADDR_W'(1);
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a stub instruction memory drives each instruction,
// expected PC commands go into a scoreboard queue that a negedge monitor drains.
module tb_pc_sequencer;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned VW     = ADDR_W + 6;

   localparam int K_INC  = 0;
   localparam int K_LOAD = 1;
   localparam int K_HALT = 2;
   localparam int K_NONE = 3;

   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] JMP  = 3'b001;
   localparam logic [2:0] BRZ  = 3'b010;
   localparam logic [2:0] CALL = 3'b011;
   localparam logic [2:0] RET  = 3'b100;
   localparam logic [2:0] HALT = 3'b101;
   localparam logic [2:0] OP6  = 3'b110;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              run = 1'b0;
   logic              imem_req;
   logic              imem_ack = 1'b0;
   logic              ir_load;
   logic [2:0]        op = '0;
   logic [ADDR_W-1:0] target = '0;
   logic              zero_flag = 1'b0;
   logic [ADDR_W-1:0] pc_value = '0;
   logic              pc_inc;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_addr;
   logic              exec_en;
   logic              halted;
   logic              stack_err;

   pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .imem_req     (imem_req),
      .imem_ack     (imem_ack),
      .ir_load      (ir_load),
      .op           (op),
      .target       (target),
      .zero_flag    (zero_flag),
      .pc_value     (pc_value),
      .pc_inc       (pc_inc),
      .pc_load      (pc_load),
      .pc_load_addr (pc_load_addr),
      .exec_en      (exec_en),
      .halted       (halted),
      .stack_err    (stack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                kind;
      logic [ADDR_W-1:0] addr;
      logic              err;
      int                lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   fetch_cyc = 0;
   int   req_n = 0;
   int   ir_n = 0;
   bit   halted_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   // Monitor: each PC command or halt entry pops one expectation.
   always @(negedge clk) begin : monitor
      exp_t             e;
      logic [VW-1:0]    obs;
      logic [VW-1:0]    want;
      int               lat;
      if (reset) begin
         halted_seen = 1'b0;
      end else if (pc_inc || pc_load || (halted && !halted_seen)) begin
         if (halted) halted_seen = 1'b1;
         checks++;
         obs = {imem_req, exec_en, pc_inc, pc_load, halted, stack_err, pc_load_addr};
         lat = cyc - fetch_cyc + 1;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got %b want no event", obs);
         end else begin
            e = sb.pop_front();
            case (e.kind)
               K_INC:   want = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {ADDR_W{1'b0}}};
               K_LOAD:  want = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e.addr};
               default: want = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e.err, {ADDR_W{1'b0}}};
            endcase
            if (obs !== want || lat != e.lat) begin
               errors++;
               $display("FAIL event kind=%0d got %b lat %0d want %b lat %0d",
                        e.kind, obs, lat, want, e.lat);
            end
         end
      end
   end

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      chk("reset_outputs", 32'({imem_req, ir_load, pc_inc, pc_load, exec_en, halted,
                                stack_err, pc_load_addr}), 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic start_run();
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   // Serve one fetch with 'delay' stall cycles; returns one tick into EXEC.
   task automatic fetch(input int delay);
      bit ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (imem_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         chk("fetch_timeout", 32'd0, 32'd1);
         return;
      end
      fetch_cyc = cyc;
      req_n     = 0;
      ir_n      = 0;
      for (int c = 0; c <= delay; c++) begin
         imem_ack = (c == delay);
         #1;
         req_n += int'(imem_req);
         ir_n  += int'(ir_load);
         @(negedge clk);
      end
      imem_ack = 1'b0;
      #1;
      chk("req_drop_decode", 32'(imem_req), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [2:0] i_op, input logic [ADDR_W-1:0] i_tgt,
                        input logic i_zf, input logic [ADDR_W-1:0] i_pc, input int delay,
                        input int kind, input logic [ADDR_W-1:0] addr, input logic err,
                        input int lat);
      exp_t e;
      if (kind != K_NONE) begin
         e.kind = kind;
         e.addr = addr;
         e.err  = err;
         e.lat  = lat;
         sb.push_back(e);
      end
      op        = i_op;
      target    = i_tgt;
      zero_flag = i_zf;
      pc_value  = i_pc;
      fetch(delay);
   endtask

   task automatic check_halted(input logic err);
      repeat (4) @(negedge clk);
      chk("halted_hold", 32'({halted, imem_req, exec_en, pc_inc, pc_load}), 32'h10);
      chk("stack_err_sticky", 32'(stack_err), 32'(err));
   endtask

   initial begin : global_timeout
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      pulse_reset();
      repeat (2) @(negedge clk);
      chk("idle_without_run", 32'({imem_req, exec_en, halted}), 32'd0);

      // Straight-line NOPs, immediate ack.
      start_run();
      instr(NOP, 11'h000, 1'b0, 11'h000, 0, K_INC, 11'h000, 1'b0, 3);
      chk("fetch_req_cycles_0", 32'(req_n), 32'd1);
      chk("fetch_ir_load_0", 32'(ir_n), 32'd1);
      instr(NOP, 11'h000, 1'b0, 11'h001, 0, K_INC, 11'h000, 1'b0, 3);
      instr(NOP, 11'h000, 1'b0, 11'h002, 0, K_INC, 11'h000, 1'b0, 3);

      // Four stall cycles before ack.
      instr(NOP, 11'h000, 1'b0, 11'h003, 4, K_INC, 11'h000, 1'b0, 7);
      chk("fetch_req_cycles_4", 32'(req_n), 32'd5);
      chk("fetch_ir_load_4", 32'(ir_n), 32'd1);

      // Branches, jump, reserved opcode.
      instr(BRZ, 11'h120, 1'b1, 11'h004, 0, K_LOAD, 11'h120, 1'b0, 3);
      instr(BRZ, 11'h120, 1'b0, 11'h120, 0, K_INC, 11'h000, 1'b0, 3);
      instr(JMP, 11'h055, 1'b0, 11'h121, 1, K_LOAD, 11'h055, 1'b0, 4);
      instr(OP6, 11'h3AA, 1'b1, 11'h055, 0, K_INC, 11'h000, 1'b0, 3);

      // Nested CALL/RET and wrap at the top address.
      instr(CALL, 11'h200, 1'b0, 11'h010, 0, K_LOAD, 11'h200, 1'b0, 3);
      instr(CALL, 11'h300, 1'b0, 11'h200, 0, K_LOAD, 11'h300, 1'b0, 3);
      instr(RET, 11'h000, 1'b0, 11'h300, 0, K_LOAD, 11'h201, 1'b0, 3);
      instr(RET, 11'h000, 1'b0, 11'h201, 2, K_LOAD, 11'h011, 1'b0, 5);
      instr(CALL, 11'h100, 1'b0, 11'h7FF, 0, K_LOAD, 11'h100, 1'b0, 3);
      instr(RET, 11'h000, 1'b0, 11'h100, 0, K_LOAD, 11'h000, 1'b0, 3);

      // Overflow on the fifth CALL.
      for (int i = 0; i < 4; i++)
         instr(CALL, 11'h040 + 11'(i), 1'b0, 11'h030 + 11'(i), 0, K_LOAD,
               11'h040 + 11'(i), 1'b0, 3);
      instr(CALL, 11'h050, 1'b0, 11'h043, 0, K_HALT, 11'h000, 1'b1, 4);
      check_halted(1'b1);
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      chk("run_ignored_halted", 32'({halted, imem_req}), 32'h2);

      // Underflow on RET with an empty stack.
      pulse_reset();
      start_run();
      instr(RET, 11'h000, 1'b0, 11'h000, 0, K_HALT, 11'h000, 1'b1, 4);
      check_halted(1'b1);

      // Plain HALT opcode.
      pulse_reset();
      start_run();
      instr(HALT, 11'h000, 1'b0, 11'h000, 0, K_HALT, 11'h000, 1'b0, 4);
      check_halted(1'b0);

      // Reset during FETCH with ack present; late ack must be ignored.
      pulse_reset();
      start_run();
      chk("pre_reset_fetch_req", 32'(imem_req), 32'd1);
      imem_ack = 1'b1;
      #2;
      pulse_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("late_ack_ignored", 32'({imem_req, ir_load, exec_en, pc_inc, pc_load}), 32'd0);
      imem_ack = 1'b0;

      // Reset during EXEC after a CALL; the stack must come back empty.
      start_run();
      instr(CALL, 11'h040, 1'b0, 11'h020, 0, K_LOAD, 11'h040, 1'b0, 3);
      op       = NOP;
      pc_value = 11'h040;
      fetch(0);
      chk("pre_reset_exec", 32'({exec_en, pc_inc}), 32'h3);
      pulse_reset();
      repeat (2) @(negedge clk);
      chk("idle_after_exec_reset", 32'({imem_req, exec_en, halted}), 32'd0);
      start_run();
      instr(RET, 11'h000, 1'b0, 11'h041, 0, K_HALT, 11'h000, 1'b1, 4);
      check_halted(1'b1);

      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
